// File: rtl/signed_20b_to_signed_sat_pkg.sv
// Shared definitions for the signed 20-bit to LENGTH-bit saturating narrower.
//   WIDE_W      : width of the incoming signed bus
//   buf_state_e : occupancy of the two-entry output buffer
package signed_20b_to_signed_sat_pkg;

  localparam int WIDE_W = 20;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/signed_20b_to_signed_sat_sat_narrow.sv
// Combinational clamp of a signed WIDE_W-bit value to signed LENGTH bits.
//   data_i : signed two's-complement input, WIDE_W bits
//   data_o : narrowed value, LENGTH bits (clamped to the min/max when out of range)
//   sat_o  : 1 when data_o is a clamped value
module sat_narrow
  import signed_20b_to_signed_sat_pkg::*;
#(
  parameter int LENGTH = 10
) (
  input  logic [WIDE_W-1:0] data_i,
  output logic [LENGTH-1:0] data_o,
  output logic              sat_o
);

  // The value fits when every bit from the MSB down to the output sign bit
  // carries the same value. With LENGTH == WIDE_W this is a single bit and
  // therefore always fits.
  logic [WIDE_W-LENGTH:0] upper;
  logic                   fits;

  assign upper = data_i[WIDE_W-1:LENGTH-1];
  assign fits  = (&upper) | (~|upper);

  always_comb begin
    data_o = data_i[LENGTH-1:0];
    sat_o  = 1'b0;
    if (!fits) begin
      sat_o  = 1'b1;
      data_o = data_i[WIDE_W-1] ? {1'b1, {(LENGTH-1){1'b0}}}
                                : {1'b0, {(LENGTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/signed_20b_to_signed_sat.sv
// Saturating narrower from a signed 20-bit stream to a signed LENGTH-bit
// stream, with a two-entry (main + skid) valid/ready buffer and a
// saturation event counter.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake, in_data is the 20-bit signed beat
//   out_valid/out_ready  : output handshake, out_data/out_sat from main register
//   sat_clear            : synchronous clear of sat_count and sat_sticky
//   sat_count            : clamped beats accepted, holds at all-ones
//   sat_sticky           : set by any accepted clamped beat
//
// state    | meaning
// ST_EMPTY | no beat buffered, outputs invalid
// ST_ONE   | main register holds the beat on out_data
// ST_TWO   | main and skid both full, input stalled
module signed_20b_to_signed_sat
  import signed_20b_to_signed_sat_pkg::*;
#(
  parameter int LENGTH = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDE_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] out_data,
  output logic              out_sat,
  input  logic              sat_clear,
  output logic [CNT_W-1:0]  sat_count,
  output logic              sat_sticky
);

  logic [LENGTH-1:0] nar_data;
  logic              nar_sat;

  // Narrowing happens ahead of the buffer so stored entries are already final.
  sat_narrow #(.LENGTH(LENGTH)) u_sat_narrow (
    .data_i (in_data),
    .data_o (nar_data),
    .sat_o  (nar_sat)
  );

  buf_state_e        state_q, state_d;
  logic [LENGTH-1:0] main_data_q, main_data_d;
  logic              main_sat_q, main_sat_d;
  logic [LENGTH-1:0] skid_data_q, skid_data_d;
  logic              skid_sat_q, skid_sat_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [CNT_W-1:0]  sat_count_q, sat_count_d;
  logic              sat_sticky_q, sat_sticky_d;

  logic acc;
  logic deq;

  assign acc = in_valid & in_ready_q;
  assign deq = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_sat_d  = main_sat_q;
    skid_data_d = skid_data_q;
    skid_sat_d  = skid_sat_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          main_data_d = nar_data;
          main_sat_d  = nar_sat;
          state_d     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (acc && deq) begin
          main_data_d = nar_data;
          main_sat_d  = nar_sat;
        end else if (acc) begin
          skid_data_d = nar_data;
          skid_sat_d  = nar_sat;
          state_d     = ST_TWO;
        end else if (deq) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (deq) begin
          main_data_d = skid_data_q;
          main_sat_d  = skid_sat_q;
          state_d     = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Clear wins over a same-cycle increment; the counter holds at all-ones.
  always_comb begin
    sat_count_d  = sat_count_q;
    sat_sticky_d = sat_sticky_q;
    if (sat_clear) begin
      sat_count_d  = '0;
      sat_sticky_d = 1'b0;
    end else if (acc && nar_sat) begin
      sat_sticky_d = 1'b1;
      if (sat_count_q != {CNT_W{1'b1}}) begin
        sat_count_d = sat_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      main_data_q  <= '0;
      main_sat_q   <= 1'b0;
      skid_data_q  <= '0;
      skid_sat_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      sat_count_q  <= '0;
      sat_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      main_data_q  <= main_data_d;
      main_sat_q   <= main_sat_d;
      skid_data_q  <= skid_data_d;
      skid_sat_q   <= skid_sat_d;
      // Both handshake outputs are registered copies of the next state.
      in_ready_q   <= (state_d != ST_TWO);
      out_valid_q  <= (state_d != ST_EMPTY);
      sat_count_q  <= sat_count_d;
      sat_sticky_q <= sat_sticky_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = main_data_q;
  assign out_sat    = main_sat_q;
  assign sat_count  = sat_count_q;
  assign sat_sticky = sat_sticky_q;

endmodule

// File: tb/tb_signed_20b_to_signed_sat.sv
// Directed bench for signed_20b_to_signed_sat with LENGTH=10, CNT_W=16.
module tb_signed_20b_to_signed_sat;

  localparam int LENGTH = 10;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [19:0]       in_data;
  logic              out_valid;
  logic              out_ready;
  logic [LENGTH-1:0] out_data;
  logic              out_sat;
  logic              sat_clear;
  logic [CNT_W-1:0]  sat_count;
  logic              sat_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  signed_20b_to_signed_sat #(.LENGTH(LENGTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .sat_clear  (sat_clear),
    .sat_count  (sat_count),
    .sat_sticky (sat_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [19:0] beats [8];
  int          idx;
  int          rx;
  int          ncyc;
  logic        ofire;
  logic        ifire;
  logic [LENGTH-1:0] ov;
  logic        saw_valid;

  initial begin
    for (int i = 0; i < 8; i++) beats[i] = 20'(i * 37 + 5);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    sat_clear = 1'b0;

    // reset state
    repeat (2) cyc();
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_in_ready",   32'(in_ready),   32'd0);
    chk("rst_out_data",   32'(out_data),   32'd0);
    chk("rst_out_sat",    32'(out_sat),    32'd0);
    chk("rst_sat_count",  32'(sat_count),  32'd0);
    chk("rst_sat_sticky", 32'(sat_sticky), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // narrowing vectors, streaming at one beat per cycle
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 20'h001FF;
    cyc();
    chk("v511_valid", 32'(out_valid), 32'd1);
    chk("v511_data",  32'(out_data),  32'h1FF);
    chk("v511_sat",   32'(out_sat),   32'd0);
    in_data = 20'h00200;
    cyc();
    chk("v512_data", 32'(out_data), 32'h1FF);
    chk("v512_sat",  32'(out_sat),  32'd1);
    in_data = 20'hFFDFF;
    cyc();
    chk("vm513_data", 32'(out_data), 32'h200);
    chk("vm513_sat",  32'(out_sat),  32'd1);
    in_data = 20'hFFE00;
    cyc();
    chk("vm512_data", 32'(out_data), 32'h200);
    chk("vm512_sat",  32'(out_sat),  32'd0);
    in_data = 20'hFFFFF;
    cyc();
    chk("vm1_data", 32'(out_data), 32'h3FF);
    chk("vm1_sat",  32'(out_sat),  32'd0);
    in_data = 20'h80000;
    cyc();
    chk("vmin_data", 32'(out_data), 32'h200);
    chk("vmin_sat",  32'(out_sat),  32'd1);
    in_valid = 1'b0;
    cyc();
    chk("drain_valid", 32'(out_valid),  32'd0);
    chk("cnt_after3",  32'(sat_count),  32'd3);
    chk("sticky_set",  32'(sat_sticky), 32'd1);

    // backpressure: only two beats fit while out_ready is low
    out_ready = 1'b0;
    idx       = 0;
    in_valid  = 1'b1;
    in_data   = beats[0];
    for (int c = 0; c < 6; c++) begin
      ifire = in_valid && in_ready;
      cyc();
      if (ifire) idx++;
      if (idx < 8) in_data = beats[idx];
      else in_valid = 1'b0;
    end
    chk("bp_accepted", 32'(idx),      32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_data", 32'(out_data), 32'(beats[0][LENGTH-1:0]));
    chk("bp_hold_valid", 32'(out_valid), 32'd1);

    out_ready = 1'b1;
    rx   = 0;
    ncyc = 0;
    while (rx < 8 && ncyc < 20) begin
      ofire = out_valid && out_ready;
      ov    = out_data;
      ifire = in_valid && in_ready;
      cyc();
      ncyc++;
      if (ofire) begin
        chk($sformatf("order_beat%0d", rx), 32'(ov), 32'(beats[rx][LENGTH-1:0]));
        rx++;
      end
      if (ifire) idx++;
      if (idx < 8) in_data = beats[idx];
      else in_valid = 1'b0;
    end
    chk("stream_count",  32'(rx),   32'd8);
    chk("stream_cycles", 32'(ncyc), 32'd8);
    cyc();
    chk("stream_empty", 32'(out_valid), 32'd0);

    // counter saturation
    sat_clear = 1'b1;
    cyc();
    sat_clear = 1'b0;
    chk("clear_cnt",    32'(sat_count),  32'd0);
    chk("clear_sticky", 32'(sat_sticky), 32'd0);
    in_valid = 1'b1;
    in_data  = 20'h00200;
    repeat (65534) @(posedge clk);
    #1;
    chk("cnt_fffe", 32'(sat_count), 32'hFFFE);
    cyc();
    chk("cnt_ffff", 32'(sat_count), 32'hFFFF);
    cyc();
    chk("cnt_hold", 32'(sat_count), 32'hFFFF);
    sat_clear = 1'b1;
    cyc();
    chk("clr_pri_cnt",    32'(sat_count),  32'd0);
    chk("clr_pri_sticky", 32'(sat_sticky), 32'd0);
    sat_clear = 1'b0;
    in_valid  = 1'b0;
    cyc();
    cyc();
    chk("idle_empty", 32'(out_valid), 32'd0);

    // reset while holding two beats
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 20'h00123;
    cyc();
    cyc();
    in_valid = 1'b0;
    chk("two_in_ready",  32'(in_ready),  32'd0);
    chk("two_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    cyc();
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    saw_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      if (out_valid) saw_valid = 1'b1;
    end
    chk("no_stale_beat", 32'(saw_valid), 32'd0);
    chk("rst_cnt_zero",  32'(sat_count), 32'd0);
    chk("rst_ready_up",  32'(in_ready),  32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/signed_20b_to_signed_sat.md
SIGNED_20B_TO_SIGNED_SAT -- requirements
Module: signed_20b_to_signed_sat

Interface
REQ-001 The block SHALL have parameter LENGTH, default 10, giving the output width in bits; legal range is 2..20.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the saturation event counter.
REQ-003 Port clk SHALL be input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n SHALL be input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port in_valid SHALL be input, 1 bit: upstream holds a valid in_data beat.
REQ-006 Port in_ready SHALL be output, 1 bit: block accepts a beat this cycle.
REQ-007 Port in_data SHALL be input, 20 bits: signed two's-complement value.
REQ-008 Port out_valid SHALL be output, 1 bit: out_data/out_sat are valid.
REQ-009 Port out_ready SHALL be input, 1 bit: downstream accepts the beat.
REQ-010 Port out_data SHALL be output, LENGTH bits: signed narrowed value.
REQ-011 Port out_sat SHALL be output, 1 bit: the beat on out_data was clamped.
REQ-012 Port sat_clear SHALL be input, 1 bit: synchronous clear of sat_count and sat_sticky.
REQ-013 Port sat_count SHALL be output, CNT_W bits: number of clamped beats accepted, saturating at all-ones.
REQ-014 Port sat_sticky SHALL be output, 1 bit: set once any clamped beat is accepted.

Function
REQ-015 A beat SHALL transfer on input when in_valid && in_ready, and on output when out_valid && out_ready.
REQ-016 Narrowing SHALL be: if in_data[19:LENGTH-1] is all-equal, out_data = in_data[LENGTH-1:0] with out_sat=0; else if in_data[19]=1, out_data = 1 followed by LENGTH-1 zeros; else out_data = 0 followed by LENGTH-1 ones; out_sat=1 in both clamp cases.
REQ-017 With LENGTH=20 the block SHALL pass data unchanged and never assert out_sat.
REQ-018 The datapath SHALL be a 2-entry buffer (main register driving outputs, skid register) with states EMPTY, ONE, TWO.
REQ-019 EMPTY: input accept -> ONE; no other transition.
REQ-020 ONE: accept only -> TWO; output transfer only -> EMPTY; accept and output transfer together -> ONE, main register loaded with the new beat.
REQ-021 TWO: output transfer -> ONE, skid contents moved to main register; no accept is possible in TWO.
REQ-022 in_ready SHALL be a registered signal, 1 exactly when the state is not TWO.
REQ-023 out_valid SHALL be 1 exactly in states ONE and TWO.
REQ-024 Latency SHALL be one cycle: a beat accepted at edge N appears on out_data after edge N when the buffer was EMPTY, or when it was ONE with a simultaneous output transfer.
REQ-025 Sustained throughput SHALL be one beat per cycle while out_ready=1.
REQ-026 out_data/out_sat SHALL stay stable while out_valid=1 and out_ready=0.
REQ-027 Beat order SHALL be preserved; no beat is dropped or duplicated.
REQ-028 sat_count SHALL increment by 1 at input acceptance of a clamped beat and SHALL hold at 2^CNT_W-1.
REQ-029 sat_clear SHALL take priority over a same-cycle increment: result 0, and sat_sticky=0.
REQ-030 Narrowing SHALL be computed before the buffer, so that stored entries hold narrowed data plus the out_sat bit.

Reset
REQ-031 While rst_n=0: state EMPTY, in_ready=1 after reset release (0 during reset), out_valid=0, out_data=0, out_sat=0, sat_count=0, sat_sticky=0.
REQ-032 Assertion of reset mid-transfer SHALL discard all buffered beats immediately; no beat emerges after release.

Structure
REQ-033 The shared package/include SHALL hold the wide-bus constant (20) and the state encodings EMPTY/ONE/TWO.
REQ-034 Clamp logic SHALL be a combinational sub-module sat_narrow (parameter LENGTH; in 20b, out LENGTH b, sat flag), instantiated once.

Verification (LENGTH=10)
REQ-035 in_data=0x001FF (511), out_ready=1 -> out_data=0x1FF, out_sat=0, one cycle later.
REQ-036 in_data=0x00200 (512) -> out_data=0x1FF, out_sat=1; in_data=0xFFDFF (-513) -> out_data=0x200, out_sat=1; in_data=0xFFE00 (-512) -> out_data=0x200, out_sat=0.
REQ-037 Stream of 8 beats, out_ready held 0 -> exactly 2 accepted, in_ready=0; release out_ready -> all 8 emerge in order, 1 beat/cycle.
REQ-038 Clamped beats with sat_count preloaded to 0xFFFE (via stimulus) -> counter stops at 0xFFFF; sat_clear together with a clamped accept -> sat_count=0, sat_sticky=0.
REQ-039 rst_n pulsed low in state TWO -> out_valid=0 asynchronously; after release, sat_count=0 and no stale beat is emitted.
